sym_counter_game: RTL and testbench

//  Top level of the SymCounter board game. Two debounced pushbuttons step a
//  4-digit BCD counter up or down. The counter is shown on the multiplexed
//  4-digit 7-segment display. The player's goal is a symmetric (palindromic)

---
 rtl/sym_counter_pkg.sv | 19 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/sym_counter_game.sv | 115 +++++++++++
 tb/tb_sym_counter_game.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_counter_pkg.sv
// Shared digit type, 7-segment constants and the palindrome test used by
// the SymCounter game.
package sym_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by decimal digit.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic is_sym(input logic [15:0] count);
        return (count[15:12] == count[3:0]) && (count[11:8] == count[7:4]);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one raw pushbutton, debounces it and emits a single-cycle
// pulse when the accepted level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic Clk100M,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          syncMeta;
    logic          syncLevel;
    logic          levelPrev;
    logic [CW-1:0] stableCnt;

    // The run counter restarts whenever the synchronized input agrees with the
    // accepted level, so only an unbroken disagreement changes the level.
    always_ff @(posedge Clk100M) begin
        if (rst) begin
            syncMeta   <= 1'b0;
            syncLevel  <= 1'b0;
            level      <= 1'b0;
            levelPrev  <= 1'b0;
            rise_pulse <= 1'b0;
            stableCnt  <= '0;
        end else begin
            syncMeta  <= raw;
            syncLevel <= syncMeta;
            if (syncLevel != level) begin
                if (stableCnt == LAST_COUNT) begin
                    level     <= syncLevel;
                    stableCnt <= '0;
                end else begin
                    stableCnt <= stableCnt + CW'(1);
                end
            end else begin
                stableCnt <= '0;
            end
            levelPrev  <= level;
            rise_pulse <= level & ~levelPrev;
        end
    end

endmodule

// File: rtl/sym_counter_game.sv
// SymCounter top level: two debounced buttons step a 4-digit BCD counter shown
// on a multiplexed 7-segment display; all decimal points light on palindromes.
module sym_counter_game #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REFRESH_BITS    = 18
) (
    input  logic       Clk100M,
    input  logic       btnS,
    input  logic       btnU,
    input  logic       btnD,
    output logic [7:0] seg,
    output logic [3:0] an
);

    import sym_counter_pkg::*;

    logic                    upLevel;
    logic                    downLevel;
    logic                    upPulse;
    logic                    downPulse;
    logic                    unusedLevels;
    logic [15:0]             count;
    logic [15:0]             incCount;
    logic [15:0]             decCount;
    logic                    upCarry;
    logic                    downBorrow;
    logic                    sym;
    logic [REFRESH_BITS-1:0] scan;
    logic [1:0]              sel;
    bcd_t                    shownDigit;
    logic [6:0]              segBits;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) upButton (
        .Clk100M    (Clk100M),
        .rst        (btnS),
        .raw        (btnU),
        .level      (upLevel),
        .rise_pulse (upPulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) downButton (
        .Clk100M    (Clk100M),
        .rst        (btnS),
        .raw        (btnD),
        .level      (downLevel),
        .rise_pulse (downPulse)
    );

    assign unusedLevels = upLevel ^ downLevel;

    // Ripple decimal carry/borrow from the ones digit upward; this gives the
    // 9999->0000 and 0000->9999 wraps for free.
    always_comb begin
        incCount   = count;
        decCount   = count;
        upCarry    = 1'b1;
        downBorrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (upCarry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    incCount[4*i +: 4] = 4'd0;
                end else begin
                    incCount[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    upCarry            = 1'b0;
                end
            end
            if (downBorrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    decCount[4*i +: 4] = 4'd9;
                end else begin
                    decCount[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    downBorrow         = 1'b0;
                end
            end
        end
    end

    assign sym = is_sym(count);
    assign sel = scan[REFRESH_BITS-1 -: 2];

    always_comb begin
        case (sel)
            2'd0:    shownDigit = count[3:0];
            2'd1:    shownDigit = count[7:4];
            2'd2:    shownDigit = count[11:8];
            default: shownDigit = count[15:12];
        endcase
        segBits = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (shownDigit == bcd_t'(i)) begin
                segBits = SEG_LUT[i];
            end
        end
    end

    // Simultaneous up and down presses cancel out.
    always_ff @(posedge Clk100M) begin
        if (btnS) begin
            count <= '0;
            scan  <= '0;
            seg   <= 8'hFF;
            an    <= 4'hF;
        end else begin
            scan <= scan + REFRESH_BITS'(1);
            an   <= ~(4'b0001 << sel);
            seg  <= {~sym, segBits};
            if (upPulse && !downPulse) begin
                count <= incCount;
            end else if (downPulse && !upPulse) begin
                count <= decCount;
            end
        end
    end

endmodule

// File: tb/tb_sym_counter_game.sv
// Scoreboard bench for sym_counter_game: directed presses queue expected counts,
// and a monitor decodes complete display frames and checks them against the queue.
`timescale 1ns/1ps
module tb_sym_counter_game;

    localparam int DEB = 4;
    localparam int RB  = 4;

    logic       Clk100M = 1'b0;
    logic       btnS    = 1'b1;
    logic       btnU    = 1'b0;
    logic       btnD    = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;

    typedef struct {
        logic [15:0] bcd;
        logic        symFlag;
        int          stamp;
    } sbEntry_t;

    sbEntry_t sbQueue[$];
    sbEntry_t sbHead;
    int       compared   = 0;
    int       mismatched = 0;
    int       cycle      = 0;
    int       expCount   = 0;

    logic [3:0] frameDigits [4];
    logic [3:0] frameDp;
    logic [3:0] frameMask;
    int         monIdx;
    int         prevIdx    = -1;
    int         frameStart = 0;

    sym_counter_game #(.DEBOUNCE_CYCLES(DEB), .REFRESH_BITS(RB)) dut (
        .Clk100M (Clk100M),
        .btnS    (btnS),
        .btnU    (btnU),
        .btnD    (btnD),
        .seg     (seg),
        .an      (an)
    );

    always #5 Clk100M = ~Clk100M;

    always @(posedge Clk100M) cycle++;

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic symOf(input int v);
        return ((v / 1000) == (v % 10)) && (((v / 100) % 10) == ((v / 10) % 10));
    endfunction

    function automatic logic [3:0] decodeSeg(input logic [6:0] s);
        case (s)
            7'b1000000: decodeSeg = 4'd0;
            7'b1111001: decodeSeg = 4'd1;
            7'b0100100: decodeSeg = 4'd2;
            7'b0110000: decodeSeg = 4'd3;
            7'b0011001: decodeSeg = 4'd4;
            7'b0010010: decodeSeg = 4'd5;
            7'b0000010: decodeSeg = 4'd6;
            7'b1111000: decodeSeg = 4'd7;
            7'b0000000: decodeSeg = 4'd8;
            7'b0010000: decodeSeg = 4'd9;
            default:    decodeSeg = 4'hF;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk100M);
        #1;
    endtask

    task automatic applyStimulus(input logic up, input logic down, input int hold);
        btnU = up;
        btnD = down;
        tick(hold);
        btnU = 1'b0;
        btnD = 1'b0;
        tick(12);
        if (up && !down) expCount = (expCount + 1) % 10000;
        else if (down && !up) expCount = (expCount + 9999) % 10000;
    endtask

    task automatic expectCount();
        int guard;
        sbQueue.push_back('{bcd: toBcd(expCount), symFlag: symOf(expCount), stamp: cycle});
        guard = 0;
        while (sbQueue.size() != 0 && guard < 100) begin
            tick(1);
            guard++;
        end
        if (sbQueue.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL frame timeout: no full frame within %0d clocks, expected count %h",
                     guard, toBcd(expCount));
            sbQueue.delete();
        end
    endtask

    // A frame counts only if it started after the expectation was queued.
    always @(negedge Clk100M) begin
        if (btnS) begin
            prevIdx   = -1;
            frameMask = 4'b0;
        end else begin
            case (an)
                4'b1110: monIdx = 0;
                4'b1101: monIdx = 1;
                4'b1011: monIdx = 2;
                4'b0111: monIdx = 3;
                default: monIdx = -1;
            endcase
            if (monIdx == 0 && prevIdx != 0) begin
                frameMask  = 4'b0;
                frameStart = cycle;
            end
            if (monIdx >= 0) begin
                frameDigits[monIdx] = decodeSeg(seg[6:0]);
                frameDp[monIdx]     = seg[7];
                frameMask[monIdx]   = 1'b1;
            end
            if (monIdx == 3 && prevIdx == 2 && frameMask == 4'b1111 &&
                sbQueue.size() > 0 && frameStart > sbQueue[0].stamp) begin
                sbHead = sbQueue.pop_front();
                checkOutput("display count",
                            {frameDigits[3], frameDigits[2], frameDigits[1], frameDigits[0]},
                            sbHead.bcd);
                checkOutput("decimal points", {12'd0, frameDp}, {12'd0, {4{~sbHead.symFlag}}});
            end
            prevIdx = monIdx;
        end
    end

    initial begin
        logic [3:0] walk [4];
        walk = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        $display("[TB] reset and digit scan");
        tick(3);
        @(negedge Clk100M);
        checkOutput("reset seg", {8'd0, seg}, 16'h00FF);
        checkOutput("reset an", {12'd0, an}, 16'h000F);
        @(posedge Clk100M);
        #1 btnS = 1'b0;
        @(posedge Clk100M);
        @(negedge Clk100M);
        checkOutput("first an", {12'd0, an}, {12'd0, walk[0]});
        checkOutput("first seg", {8'd0, seg}, 16'h0040);
        for (int k = 1; k < 4; k++) begin
            repeat (4) @(posedge Clk100M);
            @(negedge Clk100M);
            checkOutput("an walk", {12'd0, an}, {12'd0, walk[k]});
        end
        tick(1);
        expectCount();

        $display("[TB] single long press, then ten presses");
        applyStimulus(1'b1, 1'b0, 20);
        expectCount();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8);
        expectCount();

        $display("[TB] wrap down and up");
        btnS = 1'b1;
        tick(2);
        btnS = 1'b0;
        expCount = 0;
        expectCount();
        applyStimulus(1'b0, 1'b1, 8);
        expectCount();
        applyStimulus(1'b1, 1'b0, 8);
        expectCount();

        $display("[TB] bounce rejection");
        for (int i = 0; i < 15; i++) begin
            btnU = ~btnU;
            tick(2);
        end
        btnU = 1'b0;
        tick(12);
        expectCount();

        $display("[TB] preload 1220 and cross the palindrome");
        for (int i = 0; i < 1220; i++) applyStimulus(1'b1, 1'b0, 6);
        expectCount();
        applyStimulus(1'b1, 1'b0, 8);
        expectCount();
        applyStimulus(1'b1, 1'b0, 8);
        expectCount();

        $display("[TB] simultaneous presses and reset mid-debounce");
        applyStimulus(1'b1, 1'b1, 8);
        expectCount();
        btnU = 1'b1;
        tick(3);
        btnS = 1'b1;
        btnU = 1'b0;
        tick(2);
        btnS = 1'b0;
        expCount = 0;
        tick(20);
        expectCount();
        btnU = 1'b1;
        tick(3);
        btnS = 1'b1;
        tick(2);
        btnS = 1'b0;
        tick(20);
        btnU = 1'b0;
        tick(12);
        expCount = 1;
        expectCount();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        compared++;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
